// File: rtl/seg7_pkg.sv
// Shared types, segment constants and helper functions for the
// seven-segment display controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Segment patterns are bit 6 = g ... bit 0 = a, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_digit);
        logic [6:0] r;
        case (i_digit)
            4'h0:    r = 7'b1000000;
            4'h1:    r = 7'b1111001;
            4'h2:    r = 7'b0100100;
            4'h3:    r = 7'b0110000;
            4'h4:    r = 7'b0011001;
            4'h5:    r = 7'b0010010;
            4'h6:    r = 7'b0000010;
            4'h7:    r = 7'b1111000;
            4'h8:    r = 7'b0000000;
            4'h9:    r = 7'b0010000;
            4'hA:    r = 7'b0001000;
            4'hB:    r = 7'b0000011;
            4'hC:    r = 7'b1000110;
            4'hD:    r = 7'b0100001;
            4'hE:    r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // 10^n, wide enough for the largest legal digit count.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Value-offer handshake between the result/debug bus and the display
// controller.
interface seg7_display_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_value;
    logic                  dec_mode;
    logic                  lzb;
    logic [NUM_DIGITS-1:0] dp_in;

    modport master (
        output in_valid,
        output in_value,
        output dec_mode,
        output lzb,
        output dp_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  dec_mode,
        input  lzb,
        input  dp_in,
        output in_ready
    );
endinterface

// File: rtl/seg7_bcd_conv.sv
// One combinational double-dabble step: add 3 to every BCD nibble >= 5,
// then shift {bcd, bin} left by one bit.
module seg7_bcd_conv #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14
) (
    input  logic [4*NUM_DIGITS-1:0] i_bcd,
    input  logic [DATA_W-1:0]       i_bin,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [DATA_W-1:0]       o_bin
);
    localparam int unsigned BCD_W = 4 * NUM_DIGITS;

    logic [BCD_W-1:0] w_adj;

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        w_adj = i_bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign o_bcd = {w_adj[BCD_W-2:0], i_bin[DATA_W-1]};
    assign o_bin = {i_bin[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment display controller: accepts a value over a
// valid/ready handshake, optionally converts it to BCD, and drives
// registered active-low segment and decimal-point outputs.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg7_display_ctrl_if.slave      bus,
    output logic [7*NUM_DIGITS-1:0] seg_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic                    upd_o
);
    localparam int unsigned      BCD_W    = 4 * NUM_DIGITS;
    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [63:0]      DEC_MAX  = pow10(NUM_DIGITS) - 64'd1;

    state_t                  r_state;
    state_t                  w_next;
    logic [BCD_W-1:0]        r_bcd;
    logic [DATA_W-1:0]       r_bin;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf;
    logic                    r_lzb;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [7*NUM_DIGITS-1:0] r_seg;
    logic [NUM_DIGITS-1:0]   r_dpo;
    logic                    r_upd;

    logic                    w_accept;
    logic                    w_dec_ovf;
    logic                    w_hex_ovf;
    logic                    w_ovf;
    logic [BCD_W-1:0]        w_hex_digits;
    logic [BCD_W-1:0]        w_bcd_step;
    logic [DATA_W-1:0]       w_bin_step;
    logic [7*NUM_DIGITS-1:0] w_seg_next;
    logic [3:0]              w_nib;
    logic                    w_lead;

    assign bus.in_ready = (r_state == IDLE);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_dec_ovf    = (64'(bus.in_value) > DEC_MAX);

    // In hex mode the captured value is loaded straight into the digit
    // register, so both modes share the same display path.
    if (DATA_W > BCD_W) begin : g_hex_wide
        assign w_hex_ovf    = |bus.in_value[DATA_W-1:BCD_W];
        assign w_hex_digits = bus.in_value[BCD_W-1:0];
    end else begin : g_hex_narrow
        assign w_hex_ovf    = 1'b0;
        assign w_hex_digits = BCD_W'(bus.in_value);
    end

    assign w_ovf = bus.dec_mode ? w_dec_ovf : w_hex_ovf;

    seg7_bcd_conv #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W)
    ) u_bcd_conv (
        .i_bcd (r_bcd),
        .i_bin (r_bin),
        .o_bcd (w_bcd_step),
        .o_bin (w_bin_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (bus.dec_mode && !w_ovf) ? CONV : UPDATE;
                end
            end
            CONV: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = UPDATE;
                end
            end
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Segment patterns from the digit register, scanning from the most
    // significant digit down so leading zeros can be blanked.
    always_comb begin
        w_seg_next = '1;
        w_lead     = 1'b1;
        w_nib      = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_nib = r_bcd[4*(NUM_DIGITS-1-i) +: 4];
            if (r_ovf) begin
                w_seg_next[7*(NUM_DIGITS-1-i) +: 7] = SEG_DASH;
            end else if (r_lzb && w_lead && (w_nib == 4'd0) && (i != NUM_DIGITS - 1)) begin
                w_seg_next[7*(NUM_DIGITS-1-i) +: 7] = SEG_BLANK;
            end else begin
                w_seg_next[7*(NUM_DIGITS-1-i) +: 7] = hex_to_seg(w_nib);
            end
            if (w_nib != 4'd0) begin
                w_lead = 1'b0;
            end
        end
    end

    // Capture on accept, step the conversion, and latch outputs in UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_lzb <= 1'b0;
            r_dp  <= '0;
            r_seg <= '1;
            r_dpo <= '1;
            r_upd <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ovf <= w_ovf;
                        r_lzb <= bus.lzb;
                        r_dp  <= bus.dp_in;
                        r_cnt <= '0;
                        if (bus.dec_mode) begin
                            r_bcd <= '0;
                            r_bin <= bus.in_value;
                        end else begin
                            r_bcd <= w_hex_digits;
                            r_bin <= '0;
                        end
                    end
                end
                CONV: begin
                    r_bcd <= w_bcd_step;
                    r_bin <= w_bin_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                UPDATE: begin
                    r_seg <= w_seg_next;
                    r_dpo <= ~r_dp;
                    r_upd <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign seg_o = r_seg;
    assign dp_o  = r_dpo;
    assign upd_o = r_upd;

endmodule
